// File: rtl/cbx_param_pkg.sv
// Shared helpers for the X-channel connection block: select width, track
// indexing of mux inputs, and parameter legality.
package cbx_param_pkg;

  function automatic int sel_width(input int mux_size);
    return (mux_size > 2) ? $clog2(mux_size) : 1;
  endfunction

  // Track feeding input pair p of pin i; wraps around the channel.
  function automatic int track_idx(input int i, input int p, input int step, input int width);
    return (i + p * step) % width;
  endfunction

  function automatic bit params_legal(input int chan_width, input int num_ipin, input int mux_size);
    return (mux_size >= 2) && (mux_size % 2 == 0) && (chan_width >= 1) && (num_ipin >= 1);
  endfunction

endpackage

// File: rtl/cbx_param_dbuf_mux.sv
// One grid-pin input mux: MUX_SIZE:1 selection, out-of-range selects and a
// deasserted enable both drive 0.
module cb_ipin_mux
  import cbx_param_pkg::*;
#(
  parameter int MUX_SIZE = 10,
  parameter int SEL_W    = sel_width(MUX_SIZE)
) (
  input  logic [MUX_SIZE-1:0] in_i,
  input  logic [SEL_W-1:0]    sel_i,
  input  logic                en_i,
  output logic                out_o
);

  always_comb begin
    out_o = 1'b0;
    if (en_i && (int'(sel_i) < MUX_SIZE)) out_o = in_i[sel_i];
  end

endmodule

// File: rtl/cbx_param_dbuf.sv
// X-channel connection block with double-buffered scan-chain config: the
// shadow chain is shifted serially and committed whole to the active register.
module cbx_param_dbuf
  import cbx_param_pkg::*;
#(
  parameter int CHAN_WIDTH = 20,
  parameter int NUM_IPIN   = 9,
  parameter int MUX_SIZE   = 10,
  parameter int TRACK_STEP = 2
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  output logic [CHAN_WIDTH-1:0] chanx_left_out,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic [NUM_IPIN-1:0]   ipin_out,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  cfg_commit,
  output logic                  ccff_tail,
  output logic                  cfg_loaded,
  output logic                  cfg_err
);

  localparam int SEL_W     = sel_width(MUX_SIZE);
  localparam int CHAIN_LEN = NUM_IPIN * SEL_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  if (!params_legal(CHAN_WIDTH, NUM_IPIN, MUX_SIZE)) begin : g_param_check
    $error("cbx_param_dbuf: illegal CHAN_WIDTH/NUM_IPIN/MUX_SIZE");
  end

  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0] active_q, active_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 act_valid_q, act_valid_d;
  logic                 err_q, err_d;
  logic                 loaded;

  assign loaded = (count_q == CNT_FULL);

  // Commit sees the pre-edge shadow, so a simultaneous shift is not captured.
  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    count_d     = count_q;
    act_valid_d = act_valid_q;
    err_d       = 1'b0;
    if (ccff_en) begin
      shadow_d    = shadow_q << 1;
      shadow_d[0] = ccff_head;
      if (!loaded) count_d = count_q + CNT_W'(1);
    end
    if (cfg_commit) begin
      if (loaded) begin
        active_d    = shadow_q;
        act_valid_d = 1'b1;
        count_d     = ccff_en ? CNT_W'(1) : '0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shadow_q    <= '0;
      active_q    <= '0;
      count_q     <= '0;
      act_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      count_q     <= count_d;
      act_valid_q <= act_valid_d;
      err_q       <= err_d;
    end
  end

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;
  assign ccff_tail       = shadow_q[CHAIN_LEN-1];
  assign cfg_loaded      = loaded;
  assign cfg_err         = err_q;

  // Even mux inputs tap the left tracks, odd inputs the right tracks.
  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
    logic [MUX_SIZE-1:0] pin_in;
    for (genvar j = 0; j < MUX_SIZE; j++) begin : g_in
      localparam int T = track_idx(i, j / 2, TRACK_STEP, CHAN_WIDTH);
      if (j % 2 == 0) begin : g_even
        assign pin_in[j] = chanx_left_in[T];
      end else begin : g_odd
        assign pin_in[j] = chanx_right_in[T];
      end
    end
    cb_ipin_mux #(
      .MUX_SIZE(MUX_SIZE),
      .SEL_W   (SEL_W)
    ) u_mux (
      .in_i (pin_in),
      .sel_i(active_q[i*SEL_W +: SEL_W]),
      .en_i (act_valid_q),
      .out_o(ipin_out[i])
    );
  end

endmodule

// File: tb/tb_cbx_param_dbuf.sv
// Bench for cbx_param_dbuf: directed config sequences plus randomized traffic
// checked against a queue-based reference model.
module tb_cbx_param_dbuf;

  localparam int CW = 20;
  localparam int NI = 9;
  localparam int MS = 10;
  localparam int TS = 2;
  localparam int SW = 4;
  localparam int CL = NI * SW;

  logic          prog_clk = 1'b0;
  logic          prog_reset = 1'b0;
  logic [CW-1:0] chanx_left_in = '0;
  logic [CW-1:0] chanx_right_in = '0;
  logic [CW-1:0] chanx_left_out;
  logic [CW-1:0] chanx_right_out;
  logic [NI-1:0] ipin_out;
  logic          ccff_head = 1'b0;
  logic          ccff_en = 1'b0;
  logic          cfg_commit = 1'b0;
  logic          ccff_tail;
  logic          cfg_loaded;
  logic          cfg_err;

  cbx_param_dbuf dut (
    .prog_clk       (prog_clk),
    .prog_reset     (prog_reset),
    .chanx_left_in  (chanx_left_in),
    .chanx_right_in (chanx_right_in),
    .chanx_left_out (chanx_left_out),
    .chanx_right_out(chanx_right_out),
    .ipin_out       (ipin_out),
    .ccff_head      (ccff_head),
    .ccff_en        (ccff_en),
    .cfg_commit     (cfg_commit),
    .ccff_tail      (ccff_tail),
    .cfg_loaded     (cfg_loaded),
    .cfg_err        (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: shq[k] is the bit shifted in k shifts ago.
  bit shq[$];
  bit stream[$];
  int cnt_m = 0;
  int sel_m[NI];
  bit vld_m = 0;
  bit err_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_pin(input int i);
    int s;
    int t;
    s = sel_m[i];
    if (!vld_m || s >= MS) return 1'b0;
    t = (i + (s / 2) * TS) % CW;
    return (s % 2 == 0) ? chanx_left_in[t] : chanx_right_in[t];
  endfunction

  task automatic model_edge(input bit rst, input bit en, input bit head, input bit commit);
    bit ok;
    if (rst) begin
      shq.delete();
      for (int k = 0; k < CL; k++) shq.push_back(1'b0);
      stream.delete();
      cnt_m = 0;
      vld_m = 0;
      err_m = 0;
      for (int i = 0; i < NI; i++) sel_m[i] = 0;
    end else begin
      ok    = commit && (cnt_m == CL);
      err_m = commit && !ok;
      if (ok) begin
        for (int i = 0; i < NI; i++) begin
          sel_m[i] = 0;
          for (int b = 0; b < SW; b++) sel_m[i] += int'(shq[i*SW + b]) << b;
        end
        vld_m = 1;
      end
      if (en) begin
        shq.push_front(head);
        void'(shq.pop_back());
        stream.push_back(head);
      end
      if (ok) cnt_m = int'(en);
      else    cnt_m = (cnt_m + int'(en) > CL) ? CL : cnt_m + int'(en);
    end
  endtask

  task automatic check_all();
    logic [NI-1:0] e;
    for (int i = 0; i < NI; i++) e[i] = exp_pin(i);
    check("ipin_out", 32'(ipin_out), 32'(e));
    check("ccff_tail", 32'(ccff_tail), 32'(shq[CL-1]));
    check("tail_stream", 32'(ccff_tail),
          32'((stream.size() >= CL) ? stream[stream.size() - CL] : 1'b0));
    check("cfg_loaded", 32'(cfg_loaded), 32'(cnt_m == CL));
    check("cfg_err", 32'(cfg_err), 32'(err_m));
    check("left_out", 32'(chanx_left_out), 32'(chanx_right_in));
    check("right_out", 32'(chanx_right_out), 32'(chanx_left_in));
  endtask

  task automatic cyc(input bit rst, input bit en, input bit head, input bit commit);
    prog_reset = rst;
    ccff_en    = en;
    ccff_head  = head;
    cfg_commit = commit;
    @(posedge prog_clk);
    model_edge(rst, en, head, commit);
    #1;
    chanx_left_in  = CW'($urandom);
    chanx_right_in = CW'($urandom);
    prog_reset = 1'b0;
    ccff_en    = 1'b0;
    cfg_commit = 1'b0;
    #1;
    check_all();
  endtask

  // Shifts w MSB first, so w[0] ends up as the LSB of pin 0.
  task automatic shift_word(input logic [CL-1:0] w);
    for (int k = 0; k < CL; k++) cyc(1'b0, 1'b1, w[CL-1-k], 1'b0);
  endtask

  task automatic passthru(input string tag);
    chanx_left_in  = 20'hA5A5A;
    chanx_right_in = 20'h5A5A5;
    #1;
    check({tag, "_right_out"}, 32'(chanx_right_out), 32'h000A5A5A);
    check({tag, "_left_out"},  32'(chanx_left_out),  32'h0005A5A5);
  endtask

  initial begin
    for (int k = 0; k < CL; k++) shq.push_back(1'b0);
    for (int i = 0; i < NI; i++) sel_m[i] = 0;

    // Reset with shifting requested: reset must win
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_ipin", 32'(ipin_out), 32'h0);
    check("rst_tail", 32'(ccff_tail), 32'h0);
    check("rst_loaded", 32'(cfg_loaded), 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);
    passthru("pt_reset");

    // Pin 0 sel=3, all others sel=0
    shift_word(36'h3);
    check("load_loaded", 32'(cfg_loaded), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      check("pin0_right2", 32'(ipin_out[0]), 32'(chanx_right_in[2]));
      check("pin1_left1", 32'(ipin_out[1]), 32'(chanx_left_in[1]));
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    passthru("pt_active");

    // Early commit after 20 shifts
    repeat (20) cyc(1'b0, 1'b1, 1'($urandom), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("early_err", 32'(cfg_err), 32'h1);
    check("early_loaded", 32'(cfg_loaded), 32'h0);
    check("early_keep_pin0", 32'(ipin_out[0]), 32'(chanx_right_in[2]));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("early_err_clear", 32'(cfg_err), 32'h0);
    repeat (16) cyc(1'b0, 1'b1, 1'($urandom), 1'b0);
    check("early_reload", 32'(cfg_loaded), 32'h1);

    // Commit together with a shift at full count
    cyc(1'b0, 1'b1, 1'($urandom), 1'b1);
    check("simul_err", 32'(cfg_err), 32'h0);
    check("simul_loaded", 32'(cfg_loaded), 32'h0);
    repeat (37) cyc(1'b0, 1'b1, 1'($urandom), 1'b0);

    // Pin 8 out-of-range select
    shift_word({4'hC, 32'($urandom)});
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 6; r++) begin
      check("oor_pin8", 32'(ipin_out[8]), 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset mid-reload, then partial load and rejected commit
    repeat (10) cyc(1'b0, 1'b1, 1'($urandom), 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst_ipin", 32'(ipin_out), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_err", 32'(cfg_err), 32'h1);
    repeat (20) cyc(1'b0, 1'b1, 1'($urandom), 1'b0);
    check("midrst_partial", 32'(ipin_out), 32'h0);
    shift_word({$urandom, 4'($urandom)});
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int r = 0; r < 300; r++)
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom), ($urandom_range(0, 19) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
